// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch port of the 5-stage core.
// Fetches are served with one cycle of registered latency. A byte-serial
// loader fills the memory and holds the core while it does so.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN adds a trailing XOR
// checksum byte to every load session.
//
// state  | meaning
// SERVE  | memory owned by the core, fetches served
// CNT_HI | waiting for the high byte of the word count
// CNT_LO | waiting for the low byte of the word count
// DATA   | receiving data bytes, 4 per word, big-endian
// CHK    | waiting for the checksum byte (IMEM_LOAD_CHECKSUM_EN only)
module imem_fetch_responder #(
    parameter int          ADDR_W = 8,
    parameter int          DEPTH  = 256,
    parameter logic [31:0] NOP_W  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    output logic [31:0]       instruction_o,
    output logic              fetch_valid,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic [7:0]        load_byte,
    input  logic              load_byte_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [16:0] DEPTH_N = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_SERVE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA
`ifdef IMEM_LOAD_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               load_done_q, load_done_d;
    logic               load_err_q, load_err_d;
    logic [7:0]         cnt_hi_q, cnt_hi_d;
    logic [15:0]        rem_q, rem_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [23:0]        word_q, word_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    logic [31:0]        mem [DEPTH];
    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic               accept;
    logic [15:0]        n_w;
    logic               in_range;

    assign load_ready    = (state_q != S_SERVE);
    assign cpu_hold      = (state_q != S_SERVE);
    assign accept        = load_byte_valid & load_ready;
    assign n_w           = {cnt_hi_q, load_byte};
    assign in_range      = ({1'b0, fetch_addr} < DEPTH_A);
    assign instruction_o = instr_q;
    assign fetch_valid   = fetch_valid_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;

    // Next-state, fetch datapath and loader bookkeeping.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        fetch_valid_d = 1'b0;
        load_done_d   = 1'b0;
        load_err_d    = 1'b0;
        cnt_hi_d      = cnt_hi_q;
        rem_d         = rem_q;
        wptr_d        = wptr_q;
        word_d        = word_q;
        byte_idx_d    = byte_idx_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
        chk_d         = chk_q;
`endif
        mem_we        = 1'b0;
        mem_wdata     = {word_q, load_byte};

        if (state_q == S_SERVE) begin
            if (fetch_en) begin
                instr_d       = in_range ? mem[fetch_addr[PTR_W-1:0]] : NOP_W;
                fetch_valid_d = 1'b1;
            end
        end else begin
            instr_d = NOP_W;
        end

        case (state_q)
            S_SERVE: begin
                if (load_start) begin
                    state_d    = S_CNT_HI;
                    wptr_d     = '0;
                    byte_idx_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_hi_d = load_byte;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    if ({1'b0, n_w} > DEPTH_N) begin
                        load_err_d = 1'b1;
                        state_d    = S_SERVE;
                    end else if (n_w == 16'd0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        state_d     = S_CHK;
`else
                        load_done_d = 1'b1;
                        state_d     = S_SERVE;
`endif
                    end else begin
                        rem_d   = n_w;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    chk_d      = chk_q ^ load_byte;
`endif
                    word_d     = {word_q[15:0], load_byte};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + PTR_W'(1);
                        rem_d  = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                            state_d     = S_CHK;
`else
                            load_done_d = 1'b1;
                            state_d     = S_SERVE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (load_byte == chk_q) load_done_d = 1'b1;
                    else                    load_err_d  = 1'b1;
                    state_d = S_SERVE;
                end
            end
`endif
            default: state_d = S_SERVE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_SERVE;
            instr_q       <= NOP_W;
            fetch_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
            cnt_hi_q      <= '0;
            rem_q         <= '0;
            wptr_q        <= '0;
            word_q        <= '0;
            byte_idx_q    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            chk_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            fetch_valid_q <= fetch_valid_d;
            load_done_q   <= load_done_d;
            load_err_q    <= load_err_d;
            cnt_hi_q      <= cnt_hi_d;
            rem_q         <= rem_d;
            wptr_q        <= wptr_d;
            word_q        <= word_d;
            byte_idx_q    <= byte_idx_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    // Memory array is never cleared; a reset only blocks a write in that cycle.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wptr_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed load/fetch scenarios, a fetch
// vector table and randomized load sessions checked against a memory model.
module tb_imem_fetch_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fetch_addr;
    logic        fetch_en;
    logic [31:0] instruction_o;
    logic        fetch_valid;
    logic        cpu_hold;
    logic        load_start;
    logic [7:0]  load_byte;
    logic        load_byte_valid;
    logic        load_ready;
    logic        load_done;
    logic        load_err;

    imem_fetch_responder #(.ADDR_W(8), .DEPTH(256), .NOP_W(32'h0)) dut (
        .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_en(fetch_en),
        .instruction_o(instruction_o), .fetch_valid(fetch_valid),
        .cpu_hold(cpu_hold), .load_start(load_start), .load_byte(load_byte),
        .load_byte_valid(load_byte_valid), .load_ready(load_ready),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [256];
    bit          known [256];
    logic [7:0]  sess [$];

    typedef struct {
        logic        en;
        logic [7:0]  addr;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] data_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= sess[2 + i];
        return x;
    endfunction

    // Session-level reference: decode the byte stream and update the model.
    task automatic predict(output int exp_done, output int exp_err);
        int n;
        n = {sess[0], sess[1]};
        exp_done = 0;
        exp_err  = 0;
        if (n > 256) begin
            exp_err = 1;
        end else begin
            for (int w = 0; w < n; w++) begin
                model_mem[w] = {sess[2+4*w], sess[3+4*w], sess[4+4*w], sess[5+4*w]};
                known[w]     = 1'b1;
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (sess[2 + 4 * n] == data_xor(n)) exp_done = 1;
            else                                exp_err  = 1;
`else
            exp_done = 1;
`endif
        end
    endtask

    task automatic run_session(input bit fetch_busy, input int max_gap, input int stop_after,
                               output int n_done, output int n_err);
        int gap;
        n_done = 0;
        n_err  = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n_done += int'(load_done);
        n_err  += int'(load_err);
        chk("hold_after_start", {31'b0, cpu_hold}, 32'd1);
        if (fetch_busy) begin
            fetch_en   = 1'b1;
            fetch_addr = 8'd0;
        end
        for (int i = 0; i < sess.size(); i++) begin
            if (stop_after >= 0 && i == stop_after) break;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            load_byte_valid = 1'b0;
            repeat (gap) begin
                tick();
                n_done += int'(load_done);
                n_err  += int'(load_err);
                if (fetch_busy) begin
                    chk("busy_instr", instruction_o, 32'h0);
                    chk("busy_valid", {31'b0, fetch_valid}, 32'd0);
                end
            end
            load_byte       = sess[i];
            load_byte_valid = 1'b1;
            chk("ready_in_session", {31'b0, load_ready}, 32'd1);
            tick();
            load_byte_valid = 1'b0;
            n_done += int'(load_done);
            n_err  += int'(load_err);
            if (fetch_busy) begin
                chk("busy_instr", instruction_o, 32'h0);
                chk("busy_valid", {31'b0, fetch_valid}, 32'd0);
            end
        end
        fetch_en = 1'b0;
        if (stop_after < 0) begin
            chk("hold_drop_at_end", {31'b0, cpu_hold}, 32'd0);
            tick();
            n_done += int'(load_done);
            n_err  += int'(load_err);
            chk("hold_after_end", {31'b0, cpu_hold}, 32'd0);
            chk("ready_after_end", {31'b0, load_ready}, 32'd0);
        end
    endtask

    task automatic load_and_check(input string name, input bit fetch_busy, input int max_gap);
        int ed, ee, nd, ne;
        predict(ed, ee);
        run_session(fetch_busy, max_gap, -1, nd, ne);
        chk({name, "_done"}, nd, ed);
        chk({name, "_err"}, ne, ee);
    endtask

    task automatic do_fetch(input logic [7:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en = 1'b0;
        chk("fetch_instr", instruction_o, model_mem[a]);
        chk("fetch_valid", {31'b0, fetch_valid}, 32'd1);
    endtask

    task automatic scenario2_bytes();
        sess = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h03, 8'h00, 8'h03};
    endtask

    initial begin
        int nd, ne, n, a;
        logic [7:0] x;

        vecs[0] = '{1'b1, 8'd0, 32'h2001_0005, 1'b1};
        vecs[1] = '{1'b1, 8'd1, 32'hAC03_0003, 1'b1};
        vecs[2] = '{1'b0, 8'd0, 32'hAC03_0003, 1'b0};
        vecs[3] = '{1'b1, 8'd0, 32'h2001_0005, 1'b1};
        vecs[4] = '{1'b0, 8'd1, 32'h2001_0005, 1'b0};
        vecs[5] = '{1'b1, 8'd1, 32'hAC03_0003, 1'b1};

        rst = 1'b1; fetch_addr = '0; fetch_en = 1'b0; load_start = 1'b0;
        load_byte = '0; load_byte_valid = 1'b0;
        tick();
        tick();
        chk("rst_instr", instruction_o, 32'h0);
        chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_hold", {31'b0, cpu_hold}, 32'd0);
        chk("rst_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_err", {31'b0, load_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Program load with the core fetching throughout the session.
        scenario2_bytes();
`ifdef IMEM_LOAD_CHECKSUM_EN
        sess.push_back(data_xor(2));
`endif
        load_and_check("load2", 1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            fetch_en   = vecs[i].en;
            fetch_addr = vecs[i].addr;
            tick();
            chk($sformatf("vec%0d_instr", i), instruction_o, vecs[i].exp_instr);
            chk($sformatf("vec%0d_valid", i), {31'b0, fetch_valid}, {31'b0, vecs[i].exp_valid});
        end
        fetch_en = 1'b0;

        // Count overflow: N = 257.
        sess = '{8'h01, 8'h01};
        load_and_check("overflow", 1'b0, 0);
        do_fetch(8'd0);
        do_fetch(8'd1);

`ifdef IMEM_LOAD_CHECKSUM_EN
        scenario2_bytes();
        x = data_xor(2);
        sess.push_back(x ^ 8'h5A);
        load_and_check("chk_bad", 1'b0, 0);
        scenario2_bytes();
        sess.push_back(x);
        load_and_check("chk_good", 1'b0, 1);
`endif

        // Randomized sessions with byte gaps.
        for (int s = 0; s < 15; s++) begin
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(257, 400)) : int'($urandom_range(0, 6));
            sess = '{};
            sess.push_back(8'(n >> 8));
            sess.push_back(8'(n));
            if (n <= 256) begin
                for (int i = 0; i < 4 * n; i++) sess.push_back(8'($urandom));
`ifdef IMEM_LOAD_CHECKSUM_EN
                x = data_xor(n);
                if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
                sess.push_back(x);
`endif
            end
            load_and_check($sformatf("rand%0d", s), 1'($urandom_range(0, 1)), 3);
            for (int f = 0; f < 4; f++) begin
                a = int'($urandom_range(0, 7));
                if (!known[a]) a = 0;
                do_fetch(8'(a));
            end
        end

        // Reset part-way through a load: completed words survive.
        sess = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef IMEM_LOAD_CHECKSUM_EN
        sess.push_back(data_xor(1));
`endif
        load_and_check("pre_rst_load", 1'b0, 0);
        scenario2_bytes();
        run_session(1'b0, 1, 6, nd, ne);
        rst = 1'b1;
        tick();
        nd += int'(load_done);
        ne += int'(load_err);
        chk("midrst_hold", {31'b0, cpu_hold}, 32'd0);
        chk("midrst_ready", {31'b0, load_ready}, 32'd0);
        chk("midrst_instr", instruction_o, 32'h0);
        rst = 1'b0;
        tick();
        nd += int'(load_done);
        ne += int'(load_err);
        chk("midrst_no_done", nd, 0);
        chk("midrst_no_err", ne, 0);
        model_mem[0] = 32'h2001_0005;
        do_fetch(8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
